// File: rtl/riscv_pkg.sv
// riscv_pkg: ALU opcodes and forward-select codes shared by decode, hazard and execute
package riscv_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU with zero flag; undefined opcodes yield 0
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);
    always_comb begin
        Result = ALUControl == ALU_ADD ? A + B :
                 ALUControl == ALU_SUB ? A - B :
                 ALUControl == ALU_AND ? A & B :
                 ALUControl == ALU_OR  ? A | B :
                 ALUControl == ALU_XOR ? A ^ B :
                 ALUControl == ALU_SLT ? XLEN'($signed(A) < $signed(B)) : '0;
        Zero = ~|Result;
    end
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: operand forwarding, ALU, beq resolution and the EX/MEM register
module execute_cycle
    import riscv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [RW-1:0]   RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ResultW,
    input  logic            StallM,
    input  logic            FlushM,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [RW-1:0]   RD_M
);
    logic [XLEN-1:0] src_a, src_b_fwd, src_b, alu_result;
    logic            zero;

    // select code 11 is unused by the hazard unit and falls back to the register file
    always_comb begin
        src_a     = ForwardA_E == FWD_WB ? ResultW : ForwardA_E == FWD_MEM ? ALUResultM : RD1_E;
        src_b_fwd = ForwardB_E == FWD_WB ? ResultW : ForwardB_E == FWD_MEM ? ALUResultM : RD2_E;
        src_b     = ALUSrcE ? Imm_Ext_E : src_b_fwd;
        PCSrcE    = BranchE & zero;
        PCTargetE = PCE + Imm_Ext_E;
    end

    alu #(.XLEN(XLEN)) u_alu (
        .A(src_a),
        .B(src_b),
        .ALUControl(ALUControlE),
        .Result(alu_result),
        .Zero(zero)
    );

    // flush beats stall: the bubble drops its side effects but still loads data fields
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RD_M       <= '0;
        end else if (FlushM || !StallM) begin
            RegWriteM  <= RegWriteE & ~FlushM;
            MemWriteM  <= MemWriteE & ~FlushM;
            ResultSrcM <= ResultSrcE & ~FlushM;
            ALUResultM <= alu_result;
            WriteDataM <= src_b_fwd;
            PCPlus4M   <= PCPlus4E;
            RD_M       <= RD_E;
        end
    end
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed vectors; expected EX/MEM contents queued per edge, checked by a monitor
module tb_execute_cycle;
    typedef struct packed {
        logic        rw, mw, rs;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 1'b0, rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, StallM, FlushM;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE, RegWriteM, MemWriteM, ResultSrcM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    int   checks = 0, errors = 0;
    exp_t q[$];
    exp_t e6;

    always #5 clk = ~clk;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .ResultW(ResultW),
        .StallM(StallM), .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RD_M(RD_M)
    );

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, x);
        end
    endtask

    function automatic exp_t mk(input int rw, input int mw, input int rs,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] pc4, input int rd);
        exp_t e;
        e.rw = rw[0]; e.mw = mw[0]; e.rs = rs[0];
        e.alu = alu; e.wd = wd; e.pc4 = pc4; e.rd = rd[4:0];
        return e;
    endfunction

    task automatic idle();
        {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, StallM, FlushM} = '0;
        ALUControlE = 3'd0; ForwardA_E = 2'd0; ForwardB_E = 2'd0; RD_E = 5'd0;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; ResultW = 0;
    endtask

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic comb(input string n, input logic src, input logic [31:0] tgt);
        #1;
        chk({n, " PCSrcE"}, 32'(PCSrcE), 32'(src));
        chk({n, " PCTargetE"}, PCTargetE, tgt);
    endtask

    // monitor: one expected EX/MEM snapshot per rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("RegWriteM", 32'(RegWriteM), 32'(e.rw));
                chk("MemWriteM", 32'(MemWriteM), 32'(e.mw));
                chk("ResultSrcM", 32'(ResultSrcM), 32'(e.rs));
                chk("ALUResultM", ALUResultM, e.alu);
                chk("WriteDataM", WriteDataM, e.wd);
                chk("PCPlus4M", PCPlus4M, e.pc4);
                chk("RD_M", 32'(RD_M), 32'(e.rd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle(); rst = 1'b0;
        RD1_E = 3; RD2_E = 4; RegWriteE = 1'b1; MemWriteE = 1'b1; PCPlus4E = 32'h104; RD_E = 5'd5;
        StallM = 1'b1; ResultSrcE = 1'b1;
        @(negedge clk);
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1; StallM = 1'b0; ResultSrcE = 1'b0;
        comb("no branch", 1'b0, 32'h0);
        cyc(mk(1, 1, 0, 7, 4, 32'h104, 5));
        idle(); ForwardA_E = 2'b10; RD1_E = 32'h999; RD2_E = 1; RegWriteE = 1'b1; RD_E = 5'd6;
        cyc(mk(1, 0, 0, 8, 1, 0, 6));
        idle(); ForwardB_E = 2'b01; ResultW = 32'h20; MemWriteE = 1'b1; RD1_E = 32'h10; RD2_E = 32'h55;
        cyc(mk(0, 1, 0, 32'h30, 32'h20, 0, 0));
        idle(); ALUControlE = 3'b001; RD1_E = 5; RD2_E = 5; BranchE = 1'b1; PCE = 32'h100; Imm_Ext_E = 32'hFFFFFFF8;
        comb("beq taken", 1'b1, 32'hF8);
        cyc(mk(0, 0, 0, 0, 5, 0, 0));
        idle(); ALUControlE = 3'b101; RD1_E = 32'hFFFFFFFF; RD2_E = 1; BranchE = 1'b1;
        comb("beq not taken", 1'b0, 32'h0);
        cyc(mk(0, 0, 0, 1, 1, 0, 0));
        idle(); ALUSrcE = 1'b1; Imm_Ext_E = 32'h10; RD1_E = 32'h1000; RD2_E = 32'hAB;
        RegWriteE = 1'b1; ResultSrcE = 1'b1; RD_E = 5'd7; PCPlus4E = 32'h200;
        e6 = mk(1, 0, 1, 32'h1010, 32'hAB, 32'h200, 7);
        cyc(e6);
        idle(); StallM = 1'b1; RD1_E = 32'hDEAD; RD2_E = 32'hBEEF; MemWriteE = 1'b1; RD_E = 5'd3; PCPlus4E = 32'h999;
        cyc(e6);
        RD1_E = 1; ALUControlE = 3'b011;
        cyc(e6);
        idle(); StallM = 1'b1; FlushM = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1; ResultSrcE = 1'b1;
        RD1_E = 2; RD2_E = 3; RD_E = 5'd9; PCPlus4E = 32'h300;
        cyc(mk(0, 0, 0, 5, 3, 32'h300, 9));
        idle(); RD1_E = 32'hFFFFFFFF; RD2_E = 1; RegWriteE = 1'b1; BranchE = 1'b1; PCE = 32'hFFFFFFF0; Imm_Ext_E = 32'h20;
        comb("wrap target", 1'b1, 32'h10);
        cyc(mk(1, 0, 0, 0, 1, 0, 0));
        idle(); ALUControlE = 3'b111; RD1_E = 5; RD2_E = 3; BranchE = 1'b1;
        comb("op111 zero", 1'b1, 32'h0);
        cyc(mk(0, 0, 0, 0, 3, 0, 0));
        idle(); ALUControlE = 3'b110; RD1_E = 5; RD2_E = 3;
        cyc(mk(0, 0, 0, 0, 3, 0, 0));
        idle(); ALUControlE = 3'b010; RD1_E = 32'hF0F0; RD2_E = 32'hFF00;
        cyc(mk(0, 0, 0, 32'hF000, 32'hFF00, 0, 0));
        ALUControlE = 3'b011;
        cyc(mk(0, 0, 0, 32'hFFF0, 32'hFF00, 0, 0));
        ALUControlE = 3'b100;
        cyc(mk(0, 0, 0, 32'h0FF0, 32'hFF00, 0, 0));
        idle(); ALUControlE = 3'b001; RD1_E = 3; RD2_E = 5;
        cyc(mk(0, 0, 0, 32'hFFFFFFFE, 5, 0, 0));
        idle(); ALUControlE = 3'b101; RD1_E = 2; RD2_E = 32'h80000000;
        cyc(mk(0, 0, 0, 0, 32'h80000000, 0, 0));
        idle(); ForwardA_E = 2'b11; RD1_E = 32'h40; RD2_E = 2; ResultW = 32'h77;
        cyc(mk(0, 0, 0, 32'h42, 2, 0, 0));
        idle(); ForwardB_E = 2'b10; RD1_E = 1; RD2_E = 9; MemWriteE = 1'b1;
        cyc(mk(0, 1, 0, 32'h43, 32'h42, 0, 0));
        idle(); rst = 1'b0; StallM = 1'b1; FlushM = 1'b1; RegWriteE = 1'b1; MemWriteE = 1'b1;
        ALUControlE = 3'b001; RD1_E = 7; RD2_E = 7; BranchE = 1'b1; PCE = 4; Imm_Ext_E = 8;
        comb("comb in reset", 1'b1, 32'hC);
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        idle(); rst = 1'b1;
        cyc(mk(0, 0, 0, 0, 0, 0, 0));
        chk("queue drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
